// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, FSM encoding and grant ids for the memory arbiter
package mem_arb_pkg;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GRANT_IC = 2'b01,
    GRANT_DC = 2'b10
  } state_e;
  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_DC = 1'b1;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way round-robin picker, purely combinational
// Ports:
//   req_i   [1:0] request vector, bit GNT_IC = icache, bit GNT_DC = dcache
//   last_i        id of the requester that completed most recently
//   gnt_o         id of the requester picked this cycle
//   valid_o       at least one request present (gnt_o meaningful)
module arb_rr2 import mem_arb_pkg::*; (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       valid_o
);
  assign valid_o = |req_i;
  // on a tie the requester that was not served last wins
  assign gnt_o = &req_i ? ~last_i : req_i[GNT_DC];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the main-memory block port between icache and dcache
// Ports:
//   clock_i, reset_ni                     clock (state moves on falling edge), async active-low reset
//   ic_read_i, ic_address_i               icache block read request
//   ic_readdata_o, ic_busywait_o          block latched for icache, icache stall
//   dc_read_i, dc_write_i, dc_address_i,
//   dc_writedata_i                        dcache fill / write-back request
//   dc_readdata_o, dc_busywait_o          block latched for dcache, dcache stall
//   mem_read_o, mem_write_o, mem_address_o,
//   mem_writedata_o                       memory request, driven by the granted cache
//   mem_readdata_i, mem_busywait_i        memory response
module mem_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              ic_read_i,
  input  logic [ADDR_W-1:0] ic_address_i,
  output logic [DATA_W-1:0] ic_readdata_o,
  output logic              ic_busywait_o,
  input  logic              dc_read_i,
  input  logic              dc_write_i,
  input  logic [ADDR_W-1:0] dc_address_i,
  input  logic [DATA_W-1:0] dc_writedata_i,
  output logic [DATA_W-1:0] dc_readdata_o,
  output logic              dc_busywait_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_writedata_o,
  input  logic [DATA_W-1:0] mem_readdata_i,
  input  logic              mem_busywait_i
);
  import mem_arb_pkg::*;

  state_e            state_q, state_d;
  logic              seen_q, seen_d, last_q, last_d;
  logic [DATA_W-1:0] ic_rd_q, ic_rd_d, dc_rd_q, dc_rd_d, wd_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ic_req, dc_req, gnt, valid, own_req, done, complete;

  assign ic_req = ic_read_i;
  assign dc_req = dc_read_i | dc_write_i;

  arb_rr2 u_rr (
    .req_i   ({dc_req, ic_req}),
    .last_i  (last_q),
    .gnt_o   (gnt),
    .valid_o (valid)
  );

  always_ff @(negedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      seen_q  <= 1'b0;
      last_q  <= GNT_IC;
      ic_rd_q <= '0;
      dc_rd_q <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      last_q  <= last_d;
      ic_rd_q <= ic_rd_d;
      dc_rd_q <= dc_rd_d;
      addr_q  <= mem_address_o;
      wd_q    <= mem_writedata_o;
    end
  end

  // memory only counts as finished once it has been seen busy, so the
  // idle-low busywait before the memory reacts is not mistaken for completion
  always_comb begin
    own_req  = (state_q == GRANT_IC) ? ic_req : dc_req;
    done     = seen_q & ~mem_busywait_i;
    complete = (state_q != IDLE) & own_req & done;
    state_d  = (state_q == IDLE) ? (valid ? (gnt ? GRANT_DC : GRANT_IC) : IDLE)
             : ((!own_req || done) ? IDLE : state_q);
    seen_d   = (state_q != IDLE && state_d == state_q) ? (seen_q | mem_busywait_i) : 1'b0;
    last_d   = complete ? ((state_q == GRANT_DC) ? GNT_DC : GNT_IC) : last_q;
    ic_rd_d  = (complete && state_q == GRANT_IC && ic_read_i) ? mem_readdata_i : ic_rd_q;
    dc_rd_d  = (complete && state_q == GRANT_DC && mem_read_o) ? mem_readdata_i : dc_rd_q;
  end

  // a simultaneous dcache read+write is treated as the write-back
  always_comb begin
    mem_read_o      = (state_q == GRANT_IC) ? ic_read_i
                    : (state_q == GRANT_DC) ? (dc_read_i & ~dc_write_i) : 1'b0;
    mem_write_o     = (state_q == GRANT_DC) & dc_write_i;
    mem_address_o   = (state_q == GRANT_IC) ? ic_address_i
                    : (state_q == GRANT_DC) ? dc_address_i : addr_q;
    mem_writedata_o = (state_q == GRANT_DC) ? dc_writedata_i : wd_q;
    ic_busywait_o   = ic_req & ~((state_q == GRANT_IC) & done);
    dc_busywait_o   = dc_req & ~((state_q == GRANT_DC) & done);
    ic_readdata_o   = ic_rd_q;
    dc_readdata_o   = dc_rd_q;
  end
endmodule
